// File: rtl/gate_ctrl_pkg.sv
// Shared types and defaults for the gates input sequencer.
package gate_ctrl_pkg;

    localparam int DEB_CYCLES_DEF  = 500_000;
    localparam int STEP_CYCLES_DEF = 50_000_000;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-stable-cycle debouncer for
// one active-low button; level and synchronizer reset to released (1).
module btn_debounce #(
    parameter int DEB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             db_q;
    logic             db_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    // Any cycle where the synced level agrees with db restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_inc == CNT_W'(DEB_CYCLES)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/gate_seq_ctrl.sv
// Drives the active-low operand inputs of the gates block either from the
// debounced buttons (MANUAL) or from an automatic four-step pattern (SCAN).
module gate_seq_ctrl
    import gate_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in1,
    input  logic       in2,
    input  logic       btn_mode,
    output logic       gate_in1,
    output logic       gate_in2,
    output logic       scan_active,
    output logic [1:0] step_idx,
    output logic       step_stb
);

    localparam int TMR_W = $clog2(STEP_CYCLES);

    logic [2:0]       raw_bus;
    logic [2:0]       db_bus;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             stb_q, stb_d;
    logic             gate1_q, gate1_d;
    logic             gate2_q, gate2_d;
    logic             mode_prev_q;
    logic             press_q;

    assign raw_bus = {btn_mode, in2, in1};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            btn_debounce #(
                .DEB_CYCLES(DEB_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (raw_bus[gi]),
                .db   (db_bus[gi])
            );
        end
    endgenerate

    // Press is registered from the debounced mode fall; releases are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_prev_q <= 1'b1;
            press_q     <= 1'b0;
        end else begin
            mode_prev_q <= db_bus[2];
            press_q     <= mode_prev_q & ~db_bus[2];
        end
    end

    // Press is tested before terminal count so it wins a collision.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        stb_d   = 1'b0;
        case (state_q)
            MANUAL: begin
                if (press_q) begin
                    state_d = SCAN;
                    idx_d   = 2'd0;
                    tmr_d   = '0;
                    stb_d   = 1'b1;
                end
            end
            SCAN: begin
                if (press_q) begin
                    state_d = MANUAL;
                    idx_d   = 2'd0;
                    tmr_d   = '0;
                end else if (tmr_q == TMR_W'(STEP_CYCLES - 1)) begin
                    idx_d = idx_q + 2'd1;
                    tmr_d = '0;
                    stb_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: begin
                state_d = MANUAL;
                idx_d   = 2'd0;
                tmr_d   = '0;
            end
        endcase

        if (state_d == SCAN) begin
            gate1_d = ~idx_d[1];
            gate2_d = ~idx_d[0];
        end else begin
            gate1_d = db_bus[0];
            gate2_d = db_bus[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            idx_q   <= 2'd0;
            tmr_q   <= '0;
            stb_q   <= 1'b0;
            gate1_q <= 1'b1;
            gate2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            stb_q   <= stb_d;
            gate1_q <= gate1_d;
            gate2_q <= gate2_d;
        end
    end

    assign gate_in1    = gate1_q;
    assign gate_in2    = gate2_q;
    assign scan_active = (state_q == SCAN);
    assign step_idx    = idx_q;
    assign step_stb    = stb_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed scenarios plus randomized button activity checked against a
// cycle-level behavioural model of the sequencer.
module tb_gate_seq_ctrl;

    localparam int DEB  = 4;
    localparam int STEP = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in1 = 1'b1;
    logic       in2 = 1'b1;
    logic       btn_mode = 1'b1;
    logic       gate_in1;
    logic       gate_in2;
    logic       scan_active;
    logic [1:0] step_idx;
    logic       step_stb;

    int checks = 0;
    int errors = 0;

    gate_seq_ctrl #(
        .DEB_CYCLES (DEB),
        .STEP_CYCLES(STEP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in1        (in1),
        .in2        (in2),
        .btn_mode   (btn_mode),
        .gate_in1   (gate_in1),
        .gate_in2   (gate_in2),
        .scan_active(scan_active),
        .step_idx   (step_idx),
        .step_stb   (step_stb)
    );

    always #5 clk = ~clk;

    // Behavioural model: index 0 = in1, 1 = in2, 2 = btn_mode.
    bit m_s1[3];
    bit m_s2[3];
    bit m_db[3];
    int m_run[3];
    bit m_prev, m_press, m_scan, m_stb, m_g1, m_g2;
    int m_idx, m_tmr;

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 1; m_s2[b] = 1; m_db[b] = 1; m_run[b] = 0;
        end
        m_prev = 1; m_press = 0; m_scan = 0; m_stb = 0;
        m_g1 = 1; m_g2 = 1; m_idx = 0; m_tmr = 0;
    endfunction

    function automatic void model_step(input bit r0, input bit r1, input bit r2);
        bit new_press;
        bit r[3];
        r[0] = r0; r[1] = r1; r[2] = r2;
        new_press = m_prev && !m_db[2];
        m_prev = m_db[2];
        m_stb = 0;
        if (m_press) begin
            m_scan = !m_scan;
            m_idx  = 0;
            m_tmr  = 0;
            m_stb  = m_scan;
        end else if (m_scan) begin
            if (m_tmr == STEP - 1) begin
                m_idx = (m_idx + 1) % 4;
                m_tmr = 0;
                m_stb = 1;
            end else begin
                m_tmr = m_tmr + 1;
            end
        end
        if (m_scan) begin
            m_g1 = !(m_idx / 2 == 1);
            m_g2 = !(m_idx % 2 == 1);
        end else begin
            m_g1 = m_db[0];
            m_g2 = m_db[1];
        end
        // db flips once the synced level has disagreed for DEB edges in a row
        for (int b = 0; b < 3; b++) begin
            if (m_s2[b] == m_db[b]) m_run[b] = 0;
            else m_run[b] = m_run[b] + 1;
            if (m_run[b] == DEB) begin
                m_db[b]  = m_s2[b];
                m_run[b] = 0;
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = r[b];
        end
        m_press = new_press;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step(in1, in2, btn_mode);
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            in1 = (i % 9) < 6 ? 1'b0 : 1'b1;
            in2 = $urandom_range(0, 1);
            btn_mode = (i < 8) ? 1'b0 : 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_in1, gate_in2, scan_active, step_idx, step_stb} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_async got %b%b %b %b %b required 11 0 00 0",
                     gate_in1, gate_in2, scan_active, step_idx, step_stb);
        end
        in1 = 1'b1; in2 = 1'b1; btn_mode = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({gate_in1, gate_in2, scan_active, step_idx, step_stb} !== 6'b110000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %b%b %b %b %b", i,
                         gate_in1, gate_in2, scan_active, step_idx, step_stb);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_debounce();
        logic exp;
        @(negedge clk);
        in1 = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp = (k >= 7) ? 1'b0 : 1'b1;
            checks++;
            if (gate_in1 !== exp) begin
                errors++;
                $display("FAIL deb_pass edge %0d got %b required %b", k, gate_in1, exp);
            end
        end
        in1 = 1'b1;
        repeat (10) @(negedge clk);
        in1 = 1'b0;
        repeat (3) @(negedge clk);
        in1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (gate_in1 !== 1'b1) begin
                errors++;
                $display("FAIL deb_reject edge %0d got %b required 1", k, gate_in1);
            end
        end
        $display("test_debounce done");
    endtask

    // Enters SCAN; leaves c = 60 cycles after entry, idx following c/8.
    task automatic test_scan_stepping();
        logic [1:0] eidx;
        logic       estb;
        @(negedge clk);
        btn_mode = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (scan_active !== 1'b0) begin
                errors++;
                $display("FAIL scan_early edge %0d got %b required 0", k, scan_active);
            end
        end
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 2) btn_mode = 1'b1;
            eidx = 2'((c / STEP) % 4);
            estb = (c % STEP) == 0;
            checks++;
            if ({scan_active, step_idx, step_stb, gate_in1, gate_in2} !== {1'b1, eidx, estb, ~eidx}) begin
                errors++;
                $display("FAIL scan_step c %0d got act %b idx %0d stb %b gates %b%b required 1 %0d %b %b",
                         c, scan_active, step_idx, step_stb, gate_in1, gate_in2, eidx, estb, ~eidx);
            end
        end
        $display("test_scan_stepping done");
    endtask

    task automatic test_ops_ignored();
        logic [1:0] eidx;
        in1 = 1'b0; in2 = 1'b0;
        for (int c = 41; c <= 60; c++) begin
            @(negedge clk);
            eidx = 2'((c / STEP) % 4);
            checks++;
            if ({scan_active, step_idx, gate_in1, gate_in2} !== {1'b1, eidx, ~eidx}) begin
                errors++;
                $display("FAIL ops_ignored c %0d got idx %0d gates %b%b required %0d %b",
                         c, step_idx, gate_in1, gate_in2, eidx, ~eidx);
            end
        end
        btn_mode = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 7) begin
                checks++;
                if (scan_active !== 1'b1) begin
                    errors++;
                    $display("FAIL exit_early got %b required 1", scan_active);
                end
            end
        end
        checks++;
        if ({scan_active, step_idx, step_stb, gate_in1, gate_in2} !== 6'b000000) begin
            errors++;
            $display("FAIL exit_manual got act %b idx %0d stb %b gates %b%b required 0 0 0 00",
                     scan_active, step_idx, step_stb, gate_in1, gate_in2);
        end
        btn_mode = 1'b1; in1 = 1'b1; in2 = 1'b1;
        repeat (12) @(negedge clk);
        $display("test_ops_ignored done");
    endtask

    task automatic test_press_at_terminal();
        int n = 0;
        @(negedge clk);
        btn_mode = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (scan_active !== 1'b1 && n < 20);
        checks++;
        if (scan_active !== 1'b1) begin
            errors++;
            $display("FAIL collide_enter timeout got %b required 1", scan_active);
        end
        btn_mode = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 8) btn_mode = 1'b0;
            if (c == 15) begin
                checks++;
                if ({scan_active, step_idx} !== 3'b101) begin
                    errors++;
                    $display("FAIL collide_pre got act %b idx %0d required 1 1", scan_active, step_idx);
                end
            end
        end
        checks++;
        if ({scan_active, step_idx, step_stb, gate_in1, gate_in2} !== 6'b000011) begin
            errors++;
            $display("FAIL collide got act %b idx %0d stb %b gates %b%b required 0 0 0 11",
                     scan_active, step_idx, step_stb, gate_in1, gate_in2);
        end
        btn_mode = 1'b1;
        repeat (12) @(negedge clk);
        $display("test_press_at_terminal done");
    endtask

    task automatic test_reset_mid_scan();
        int n = 0;
        @(negedge clk);
        btn_mode = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (n == 10) btn_mode = 1'b1;
        end while (step_idx !== 2'd2 && n < 60);
        btn_mode = 1'b1;
        checks++;
        if ({scan_active, step_idx} !== 3'b110) begin
            errors++;
            $display("FAIL midscan_reach got act %b idx %0d required 1 2", scan_active, step_idx);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gate_in1, gate_in2, scan_active, step_idx, step_stb} !== 6'b110000) begin
            errors++;
            $display("FAIL midscan_reset got %b%b %b %b %b required 11 0 00 0",
                     gate_in1, gate_in2, scan_active, step_idx, step_stb);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (scan_active !== 1'b1 && n < 20);
        checks++;
        if ({scan_active, step_idx, step_stb, gate_in1, gate_in2} !== 6'b100111 || n != 8) begin
            errors++;
            $display("FAIL midscan_restart after %0d got act %b idx %0d stb %b gates %b%b required 8 1 0 1 11",
                     n, scan_active, step_idx, step_stb, gate_in1, gate_in2);
        end
        btn_mode = 1'b1;
        repeat (16) @(negedge clk);
        $display("test_reset_mid_scan done");
    endtask

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            exp = {m_g1, m_g2, m_scan, 2'(m_idx), m_stb};
            checks++;
            if ({gate_in1, gate_in2, scan_active, step_idx, step_stb} !== exp) begin
                errors++;
                if (errors < 40)
                    $display("FAIL random cyc %0d got %b%b %b %b %b required %b%b %b %b %b", i,
                             gate_in1, gate_in2, scan_active, step_idx, step_stb,
                             exp[5], exp[4], exp[3], exp[2:1], exp[0]);
            end
            if ($urandom_range(0, 5) == 0) in1 = ~in1;
            if ($urandom_range(0, 5) == 0) in2 = ~in2;
            if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_debounce();
        test_scan_stepping();
        test_ops_ignored();
        test_press_at_terminal();
        test_reset_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Input sequencer for the `gates` logic datapath: takes three raw active-low board buttons and drives the two active-low operand inputs of the gates block. In MANUAL mode it passes the debounced operand buttons through. In SCAN mode it steps automatically through all four operand combinations at a fixed rate, so the AND/OR/XOR LEDs can be checked without pressing buttons. It sits between the board pins and the gates instance.

## Interface
- `DEB_CYCLES`, default 500_000: consecutive stable cycles required before a debounced button changes level (10 ms at 50 MHz); must be ≥ 1.
- `STEP_CYCLES`, default 50_000_000: cycles per SCAN combination (1 s at 50 MHz); must be ≥ 2.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in1`  in  1  raw operand button 1, active-low (0 = pressed), asynchronous to `clk`.
- `in2`  in  1  raw operand button 2, active-low, asynchronous.
- `btn_mode`  in  1  raw mode button, active-low, asynchronous.
- `gate_in1`  out  1  operand 1 to gates, active-low (same polarity as `in1`).
- `gate_in2`  out  1  operand 2 to gates, active-low.
- `scan_active`  out  1  1 while in SCAN.
- `step_idx`  out  2  current SCAN combination; `{op1, op2}` in logical (active-high) form.
- `step_stb`  out  1  one-cycle pulse when a new SCAN combination is applied.

## Operation
- Each raw button passes through:
  - a 2-flop synchronizer;
  - a debouncer holding level `db` (reset value 1 = released) and a counter. The counter increments while the synced level ≠ `db`. It clears whenever the synced level = `db`. When the counter reaches DEB_CYCLES, `db` takes the synced level and the counter clears.
- Mode press: a 1→0 transition of debounced `btn_mode` produces a one-cycle `press` pulse. Releases are ignored.
- FSM, two states, MANUAL and SCAN:
  - **MANUAL:**
    - `gate_in1` = `db_in1`, `gate_in2` = `db_in2`, registered.
    - On `press`: go to SCAN, set `step_idx` = 0, clear the timer, pulse `step_stb`.
  - **SCAN:**
    - `gate_in1` = ~`step_idx[1]`, `gate_in2` = ~`step_idx[0]`.
    - Timer counts 0..STEP_CYCLES-1. At terminal count: `step_idx` increments and wraps 3→0, the timer returns to 0, and `step_stb` pulses.
    - On `press`: go to MANUAL, set `step_idx` = 0, clear the timer, no `step_stb`.
    - `in1`/`in2` have no effect on the outputs. Their debouncers keep running.
- If `press` and terminal count occur in the same cycle, `press` wins: mode exits and no step occurs.
- Reset, at any time including mid-SCAN or mid-debounce:
  - state MANUAL;
  - `gate_in1` = `gate_in2` = 1;
  - `scan_active` = 0, `step_idx` = 0, `step_stb` = 0;
  - all debounce levels = 1, all counters = 0, synchronizer flops = 1.

## Timing
- All outputs are registered and change only on a `clk` rising edge (or on reset assertion).
- Raw level change to `db` change:
  - 2 cycles of synchronizer;
  - then `db` updates on the DEB_CYCLES-th rising edge at which the synced level differs from `db` (edge 1 is the edge where the synced flop first shows the new level);
  - any bounce that returns the synced level to `db` restarts the count.
- `db` change to `gate_in*` (MANUAL): 1 cycle.
- `db_mode` fall to `press`: 1 cycle.
- `press` to `scan_active`/`gate_in*`/`step_stb`: 1 cycle. `step_idx` = 0 therefore holds for exactly STEP_CYCLES cycles after entry.
- SCAN step period: exactly STEP_CYCLES cycles. `step_stb` is high in the same cycle that the new `step_idx` and `gate_in*` first appear.

## Structure
- Shared package `gate_ctrl_pkg`:
  - state encoding MANUAL = 1'b0, SCAN = 1'b1;
  - default parameter values.
- Sub-module `btn_debounce` (parameter DEB_CYCLES; ports `clk`, `rst_n`, `raw`, `db`), containing the synchronizer, counter and level. It is instantiated three times.
- Counter widths: `$clog2(DEB_CYCLES+1)` and `$clog2(STEP_CYCLES)`.

## Test plan
All scenarios use DEB_CYCLES=4 and STEP_CYCLES=8.
1. **Reset values:** assert `rst_n`=0 mid-stream. All outputs take their reset values immediately: `gate_in1`=`gate_in2`=1, `scan_active`=0, `step_idx`=0, `step_stb`=0.
2. **Debounce pass and reject:**
   - `in1` held 0 steadily → `gate_in1` falls exactly 2+4+1 = 7 cycles after the raw edge, per the Timing chain.
   - `in1` pulses 0 for 3 cycles then returns to 1 → `gate_in1` stays 1.
3. **Mode entry and stepping:**
   - Press `btn_mode` → `scan_active`=1, `step_stb` pulses, and `step_idx` steps 0,1,2,3,0 every 8 cycles.
   - At each index, `{gate_in1, gate_in2}` = 11, 10, 01, 00, 11.
4. **Operand buttons ignored in SCAN:** hold `in1`=`in2`=0 during SCAN → outputs follow `step_idx` only. Press mode again → MANUAL, and `gate_in1`=`gate_in2`=0 one cycle later.
5. **Simultaneous press and terminal count:** align `press` with timer terminal count → `scan_active`=0, `step_idx`=0, no `step_stb`.
6. **Reset mid-SCAN:** assert reset while `step_idx`=2 → MANUAL with reset values. The first `btn_mode` press after release restarts SCAN at index 0.
